// File: rtl/mips_instr_stim_gen_pkg.sv
// Shared types, ISA literals and helpers for the MIPS instruction stimulus generator.
package mips_instr_stim_gen_pkg;

  // Instruction kinds. The numeric value is the kind index seen on out_kind and kind_mask.
  typedef enum logic [3:0] {
    K_LW   = 4'd0,
    K_SW   = 4'd1,
    K_BEQ  = 4'd2,
    K_ADDI = 4'd3,
    K_J    = 4'd4,
    K_ADD  = 4'd5,
    K_SUB  = 4'd6,
    K_AND  = 4'd7,
    K_OR   = 4'd8,
    K_SLT  = 4'd9
  } instr_kind_e;

  // Generation modes. Encoding 3 behaves exactly like RANDOM.
  typedef enum logic [1:0] {
    MODE_DIRECTED   = 2'd0,
    MODE_SEQUENTIAL = 2'd1,
    MODE_RANDOM     = 2'd2,
    MODE_RANDOM_ALT = 2'd3
  } gen_mode_e;

  localparam int NUM_KINDS = 10;

  // Opcode and funct literals of the supported subset.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Kind -> opcode table.
  function automatic logic [5:0] kind_opcode(input logic [3:0] kind);
    logic [5:0] op;
    case (kind)
      K_LW:    op = OP_LW;
      K_SW:    op = OP_SW;
      K_BEQ:   op = OP_BEQ;
      K_ADDI:  op = OP_ADDI;
      K_J:     op = OP_J;
      default: op = OP_RTYPE;
    endcase
    return op;
  endfunction

  // Kind -> funct table (only meaningful for R-type kinds).
  function automatic logic [5:0] kind_funct(input logic [3:0] kind);
    logic [5:0] fn;
    case (kind)
      K_ADD:   fn = FN_ADD;
      K_SUB:   fn = FN_SUB;
      K_AND:   fn = FN_AND;
      K_OR:    fn = FN_OR;
      K_SLT:   fn = FN_SLT;
      default: fn = 6'h00;
    endcase
    return fn;
  endfunction

  // First enabled kind at index >= from (from must be 0..9), wrapping past 9 to 0.
  // Returns 0 when nothing is enabled; callers never start a burst in that case.
  function automatic logic [3:0] first_enabled(input logic [9:0] mask, input logic [3:0] from);
    logic [3:0] res;
    logic       found;
    logic [4:0] idx;
    res   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_KINDS; i++) begin
      idx = {1'b0, from} + 5'(i);
      if (idx >= 5'd10) idx = idx - 5'd10;
      if (!found && mask[idx[3:0]]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next kind index, wrapping 9 -> 0.
  function automatic logic [3:0] kind_wrap_inc(input logic [3:0] kind);
    return (kind >= 4'd9) ? 4'd0 : kind + 4'd1;
  endfunction

endpackage

// File: rtl/mips_lfsr.sv
// Right-shifting Galois LFSR with synchronous load and advance enables.
module mips_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h8020_0003,
  parameter logic [WIDTH-1:0] SEED  = 32'hACE1_2025
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  // Load has priority; otherwise shift right and fold in POLY when bit 0 falls out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= {1'b0, state[WIDTH-1:1]} ^ (state[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/mips_instr_stim_gen.sv
// MIPS instruction stimulus generator: emits legal lw/sw/beq/addi/j/add/sub/and/or/slt
// encodings over a valid/ready stream in directed, sequential or LFSR-random order.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready are both 1.
// While out_valid is high and out_ready is low, out_instr/out_kind hold steady because
// they are a pure function of registered state that only changes on a transfer.
module mips_instr_stim_gen
  import mips_instr_stim_gen_pkg::*;
#(
  parameter int                    INSTR_WIDTH   = 32,
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 32'hACE1_2025,
  parameter int                    CNT_WIDTH     = 16,
  parameter int                    MEM_ADDR_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [9:0]             kind_mask,
  input  logic [3:0]             dir_kind,
  input  logic [4:0]             reg_mask,
  input  logic [CNT_WIDTH-1:0]   num_instr,
  input  logic                   seed_load,
  input  logic [LFSR_WIDTH-1:0]  seed_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [3:0]             out_kind,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [CNT_WIDTH-1:0]   issued_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  gen_mode_e             mode_q;
  logic [9:0]            kind_mask_q;
  logic [3:0]            dir_kind_q;
  logic [4:0]            reg_mask_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [3:0]            seq_idx;
  logic                  cfg_err_q;
  logic                  start_ok;
  logic                  accept;
  logic                  lfsr_load;
  logic [LFSR_WIDTH-1:0] lfsr_load_val;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [3:0]            rnd_start;
  logic [3:0]            cur_kind;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [15:0]           mem_imm;
  logic [5:0]            opcode;
  logic [31:0]           instr_enc;

  // DIRECTED needs no kinds enabled; the other modes need at least one.
  assign start_ok = (gen_mode_e'(mode) == MODE_DIRECTED) || (kind_mask != 10'd0);
  assign accept   = out_valid & out_ready;
  assign cnt_next = cnt_q + CNT_WIDTH'(1);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign lfsr_load     = (state == S_IDLE) && seed_load;
  assign lfsr_load_val = (seed_in == '0) ? LFSR_WIDTH'(1) : seed_in;

  mips_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .POLY  (LFSR_WIDTH'(LFSR_POLY)),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .advance  (accept),
    .state    (lfsr)
  );

  // Burst FSM with frozen configuration, issued counter and sequential kind pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= MODE_DIRECTED;
      kind_mask_q <= '0;
      dir_kind_q  <= '0;
      reg_mask_q  <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      seq_idx     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              state       <= S_RUN;
              mode_q      <= gen_mode_e'(mode);
              kind_mask_q <= kind_mask;
              dir_kind_q  <= dir_kind;
              reg_mask_q  <= reg_mask;
              num_q       <= num_instr;
              cnt_q       <= '0;
              seq_idx     <= first_enabled(kind_mask, 4'd0);
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt_q   <= cnt_next;
            seq_idx <= first_enabled(kind_mask_q, kind_wrap_inc(seq_idx));
          end
          // stop wins over a completing accept; the accept above is still counted.
          if (stop) begin
            state <= S_DONE;
          end else if (accept && (num_q != '0) && (cnt_next == num_q)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Kind selection from the frozen mode and the current LFSR state.
  always_comb begin
    rnd_start = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
    case (mode_q)
      MODE_DIRECTED:   cur_kind = (dir_kind_q >= 4'd10) ? 4'd0 : dir_kind_q;
      MODE_SEQUENTIAL: cur_kind = seq_idx;
      default:         cur_kind = first_enabled(kind_mask_q, rnd_start);
    endcase
  end

  // Instruction encoding; lw/sw offsets stay word aligned inside the data memory window.
  always_comb begin
    rs      = lfsr[8:4]   & reg_mask_q;
    rt      = lfsr[13:9]  & reg_mask_q;
    rd      = lfsr[18:14] & reg_mask_q;
    opcode  = kind_opcode(cur_kind);
    mem_imm = '0;
    mem_imm[MEM_ADDR_BITS-1:2] = lfsr[MEM_ADDR_BITS+15:18];
    case (cur_kind)
      K_LW, K_SW:    instr_enc = {opcode, rs, rt, mem_imm};
      K_BEQ, K_ADDI: instr_enc = {opcode, rs, rt, lfsr[31:16]};
      K_J:           instr_enc = {opcode, lfsr[25:0]};
      default:       instr_enc = {OP_RTYPE, rs, rt, rd, 5'd0, kind_funct(cur_kind)};
    endcase
  end

  assign out_valid  = (state == S_RUN);
  assign out_instr  = out_valid ? instr_enc : '0;
  assign out_kind   = out_valid ? cur_kind : 4'd0;
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign cfg_err    = cfg_err_q;
  assign issued_cnt = cnt_q;

endmodule

// File: doc/mips_instr_stim_gen.md
Name: mips_instr_stim_gen

Overview:
- Synthesizable, parametrised MIPS instruction stimulus generator.
- Produces legal encodings of the supported set (lw, sw, beq, addi, j, add, sub, and, or, slt) over a valid/ready stream.
- Feeds mips_core's instruction port in standalone and emulation benches, in place of software-side randomisation.
- Supports directed, sequential and LFSR-random modes, with kind masking, register-range restriction, memory-safe load/store offsets and burst counts.

Parameters:
INSTR_WIDTH, 32, instruction width; fixed by ISA, only 32 legal
LFSR_WIDTH, 32, generator state width
SEED, 32'hACE1_2025, reset/default LFSR seed; must be nonzero
CNT_WIDTH, 16, width of burst length and issued counter
MEM_ADDR_BITS, 8, lw/sw offset confined to [0, 2^MEM_ADDR_BITS), word aligned

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins burst when IDLE, ignored otherwise
stop  in  1  aborts RUN burst
mode  in  2  0 DIRECTED, 1 SEQUENTIAL, 2 RANDOM, 3 treated as RANDOM
kind_mask  in  10  enabled kinds, bit i = kind index i
dir_kind  in  4  kind used in DIRECTED mode
reg_mask  in  5  ANDed onto rs/rt/rd fields
num_instr  in  CNT_WIDTH  burst length; 0 = unbounded until stop
seed_load  in  1  IDLE only: load seed_in into LFSR
seed_in  in  LFSR_WIDTH  seed value; 0 loads 1
out_valid  out  1  instruction valid
out_ready  in  1  consumer accepts
out_instr  out  INSTR_WIDTH  encoded instruction
out_kind  out  4  kind index of out_instr
busy  out  1  high in RUN
done  out  1  one-cycle pulse at burst end
cfg_err  out  1  one-cycle pulse on rejected start
issued_cnt  out  CNT_WIDTH  accepted instructions in current/last burst

Behaviour:
- Kind indices: 0 LW(0x23), 1 SW(0x2B), 2 BEQ(0x04), 3 ADDI(0x08), 4 J(0x02), 5 ADD, 6 SUB, 7 AND, 8 OR, 9 SLT.
  - R-type: opcode 0, shamt 0, funct 0x20/0x22/0x24/0x25/0x2A.
- Reset values: all outputs 0; state IDLE; LFSR = SEED.
- LFSR:
  - Galois, polynomial 0x80200003.
  - Advances exactly once per accepted handshake (out_valid & out_ready); otherwise holds.
  - seed_load honoured only in IDLE.
- Fields from current LFSR state L:
  - rs = L[8:4]&reg_mask, rt = L[13:9]&reg_mask, rd = L[18:14]&reg_mask.
  - addi imm = L[31:16].
  - beq imm = L[31:16].
  - lw/sw imm = L[MEM_ADDR_BITS+15:18] shifted into bits [MEM_ADDR_BITS-1:2]; bits [1:0] = 0; upper bits = 0.
  - j target = L[25:0].
- Kind selection:
  - DIRECTED: dir_kind; a value ≥10 is treated as 0.
  - RANDOM: c = L[3:0], minus 10 if ≥10. Result is the first enabled kind at index ≥ c, wrapping to 0.
  - SEQUENTIAL: first enabled kind at or after index 0 at burst start; after each accept, the next enabled index, wrapping.
  - kind_mask is ignored in DIRECTED.
- FSM IDLE/RUN/DONE:
  - IDLE→RUN: start with kind_mask≠0, or start in DIRECTED mode. Latch mode, kind_mask, dir_kind, reg_mask, num_instr. Clear issued_cnt.
  - Latched configuration is frozen during RUN.
  - Rejected start (kind_mask=0, non-DIRECTED): cfg_err pulse, stay IDLE.
  - RUN: out_valid=1 from the cycle after start; combinational encoding of registered state.
  - out_instr/out_kind hold stable while valid & !ready; throughput 1 instr/cycle under constant ready.
  - RUN→DONE: accept with issued_cnt+1 == num_instr (num_instr≠0), or stop asserted (stop wins over a same-cycle accept; that accept still counts).
  - DONE: done=1, out_valid=0, one cycle → IDLE.
- start during RUN/DONE: ignored.
- issued_cnt wraps at 2^CNT_WIDTH in unbounded mode.
- Asynchronous reset mid-burst: immediate return to reset values, LFSR reseeded to SEED.

Decomposition:
- mips_pkg additions:
  - instr_kind_e enum (10 kinds).
  - Kind→opcode and kind→funct constant tables.
  - LFSR polynomial constant.
  - Mode enum gen_mode_e.
- Opcode/funct literals reuse the existing mips_isa_pkg values.
- One sub-module: mips_lfsr (parametrised width/poly/seed, load and advance enables).

Test Plan:
- DIRECTED dir_kind=5, reg_mask=0, num_instr=3, ready=1 → exactly 3 beats of 0x00000020 on consecutive cycles; done pulse next cycle; issued_cnt=3.
- DIRECTED dir_kind=1, reg_mask=0, 50 beats → every instr[31:26]=0x2B, instr[25:16]=0, instr[15:8]=0, instr[1:0]=0.
- SEQUENTIAL kind_mask=10'b0000010011, num_instr=6 → out_kind 0,1,4,0,1,4.
- RANDOM kind_mask=10'b1000000000, 20 beats → all funct 0x2A, opcode 0; deassert ready 5 cycles mid-burst → out_instr constant, issued_cnt frozen.
- start with mode=RANDOM, kind_mask=0 → cfg_err pulse, busy stays 0, out_valid 0.
- num_instr=0, stop after 7 accepts; then reset mid-burst and reseed seed_in=0 → burst ends with issued_cnt=7; after reset, outputs 0; LFSR state equals 1 after seed_load.
